// File: rtl/cursor_ctrl.sv
// Text-mode cursor controller: CPU staging registers, frame-synchronous
// active copy and a vsync-driven blink generator.
module cursor_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic [7:0]  cpu_rdata,
   input  logic        vsync_start,
   output logic [10:0] match_address,
   output logic        cursor_disable,
   output logic [3:0]  start_scanline,
   output logic [3:0]  end_scanline,
   output logic        blink_state
);

   localparam logic [1:0] A_LO    = 2'd0;
   localparam logic [1:0] A_HI    = 2'd1;
   localparam logic [1:0] A_START = 2'd2;
   localparam logic [1:0] A_END   = 2'd3;

   // staging (CPU-visible) copy
   logic [10:0] stg_addr_q, stg_addr_d;
   logic [3:0]  stg_start_q, stg_start_d;
   logic [3:0]  stg_end_q, stg_end_d;
   logic        stg_dis_q, stg_dis_d;
   logic        stg_fast_q, stg_fast_d;
   logic        stg_off_q, stg_off_d;

   // active (frame-stable) copy
   logic [10:0] act_addr_q, act_addr_d;
   logic [3:0]  act_start_q, act_start_d;
   logic [3:0]  act_end_q, act_end_d;
   logic        act_dis_q, act_dis_d;
   logic        act_fast_q, act_fast_d;
   logic        act_off_q, act_off_d;

   logic [4:0]  cnt_q, cnt_d;
   logic        blink_q, blink_d;
   logic [7:0]  rdata_q, rdata_d;

   // register file, read port, frame transfer and blink generator
   always_comb begin
      stg_addr_d  = stg_addr_q;
      stg_start_d = stg_start_q;
      stg_end_d   = stg_end_q;
      stg_dis_d   = stg_dis_q;
      stg_fast_d  = stg_fast_q;
      stg_off_d   = stg_off_q;
      act_addr_d  = act_addr_q;
      act_start_d = act_start_q;
      act_end_d   = act_end_q;
      act_dis_d   = act_dis_q;
      act_fast_d  = act_fast_q;
      act_off_d   = act_off_q;
      cnt_d       = cnt_q;
      blink_d     = blink_q;
      rdata_d     = rdata_q;

      if (cpu_we) begin
         case (cpu_addr)
            A_LO:    stg_addr_d[7:0]  = cpu_wdata;
            A_HI:    stg_addr_d[10:8] = cpu_wdata[2:0];
            A_START: begin
               stg_start_d = cpu_wdata[3:0];
               stg_dis_d   = cpu_wdata[4];
               stg_fast_d  = cpu_wdata[5];
               stg_off_d   = cpu_wdata[6];
            end
            default: stg_end_d = cpu_wdata[3:0];
         endcase
      end

      // reads see the pre-write staging value
      if (cpu_re) begin
         case (cpu_addr)
            A_LO:    rdata_d = stg_addr_q[7:0];
            A_HI:    rdata_d = {5'd0, stg_addr_q[10:8]};
            A_START: rdata_d = {1'b0, stg_off_q, stg_fast_q,
                                stg_dis_q, stg_start_q};
            A_END:   rdata_d = {4'd0, stg_end_q};
            default: rdata_d = 8'd0;
         endcase
      end

      // blink mode used on a vsync is the one being made active
      if (vsync_start) begin
         act_addr_d  = stg_addr_q;
         act_start_d = stg_start_q;
         act_end_d   = stg_end_q;
         act_dis_d   = stg_dis_q;
         act_fast_d  = stg_fast_q;
         act_off_d   = stg_off_q;
         if (stg_off_q) begin
            cnt_d   = 5'd0;
            blink_d = 1'b1;
         end else if (cnt_q >= (stg_fast_q ? 5'd7 : 5'd15)) begin
            cnt_d   = 5'd0;
            blink_d = ~blink_q;
         end else begin
            cnt_d   = cnt_q + 5'd1;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_addr_q  <= 11'd0;
         stg_start_q <= 4'd14;
         stg_end_q   <= 4'd15;
         stg_dis_q   <= 1'b1;
         stg_fast_q  <= 1'b0;
         stg_off_q   <= 1'b0;
         act_addr_q  <= 11'd0;
         act_start_q <= 4'd14;
         act_end_q   <= 4'd15;
         act_dis_q   <= 1'b1;
         act_fast_q  <= 1'b0;
         act_off_q   <= 1'b0;
         cnt_q       <= 5'd0;
         blink_q     <= 1'b0;
         rdata_q     <= 8'd0;
      end else begin
         stg_addr_q  <= stg_addr_d;
         stg_start_q <= stg_start_d;
         stg_end_q   <= stg_end_d;
         stg_dis_q   <= stg_dis_d;
         stg_fast_q  <= stg_fast_d;
         stg_off_q   <= stg_off_d;
         act_addr_q  <= act_addr_d;
         act_start_q <= act_start_d;
         act_end_q   <= act_end_d;
         act_dis_q   <= act_dis_d;
         act_fast_q  <= act_fast_d;
         act_off_q   <= act_off_d;
         cnt_q       <= cnt_d;
         blink_q     <= blink_d;
         rdata_q     <= rdata_d;
      end
   end

   assign cpu_rdata      = rdata_q;
   assign match_address  = act_addr_q;
   assign cursor_disable = act_dis_q;
   assign start_scanline = act_start_q;
   assign end_scanline   = act_end_q;
   assign blink_state    = blink_q;

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 The block SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: cpu_addr  input  2  register select (0 CUR_LO, 1 CUR_HI, 2 CUR_START, 3 CUR_END).
REQ-005 Port: cpu_wdata  input  8  write data.
REQ-006 Port: cpu_we  input  1  write strobe, one write per asserted cycle.
REQ-007 Port: cpu_re  input  1  read strobe.
REQ-008 Port: cpu_rdata  output  8  registered read data.
REQ-009 Port: vsync_start  input  1  one-cycle pulse at the start of vertical retrace.
REQ-010 Port: match_address  output  11  active cursor VRAM address.
REQ-011 Port: cursor_disable  output  1  active cursor hide flag.
REQ-012 Port: start_scanline  output  4  active cursor first scanline.
REQ-013 Port: end_scanline  output  4  active cursor last scanline.
REQ-014 Port: blink_state  output  1  cursor visible phase, high = visible.

Function
REQ-015 Staging registers SHALL be written on cpu_we: CUR_LO[7:0] = addr[7:0]; CUR_HI[2:0] = addr[10:8]; CUR_START[3:0] = start, [4] = disable, [5] = blink_fast, [6] = blink_off; CUR_END[3:0] = end; unlisted bits ignored.
REQ-016 Active outputs (match_address, cursor_disable, start_scanline, end_scanline, blink mode) SHALL load from staging only in the cycle vsync_start is high; CPU writes never change outputs mid-frame.
REQ-017 A write coinciding with vsync_start SHALL update staging only; active outputs take the pre-write staging value, and the new value applies at the next vsync_start.
REQ-018 On cpu_re, cpu_rdata SHALL present the addressed staging register one cycle later, unused bits 0; cpu_rdata holds its value when cpu_re is low.
REQ-019 Read and write to the same address in the same cycle SHALL return the pre-write value.
REQ-020 The blink counter SHALL be 5 bits and advance only on vsync_start; half-period N = 8 frames when active blink_fast = 1, else 16.
REQ-021 On vsync_start with counter >= N-1, the counter SHALL clear to 0 and blink_state SHALL toggle; otherwise the counter increments.
REQ-022 The >= comparison SHALL guarantee a toggle at the next vsync_start when switching slow to fast with counter >= 7.
REQ-023 When active blink_off = 1, blink_state SHALL be forced high and the counter held at 0; clearing blink_off restarts blinking from counter 0 with blink_state high.
REQ-024 Latency: staging update 1 cycle after cpu_we; outputs update 1 cycle after the vsync_start edge; blink_state changes in the same cycle as the active registers.
REQ-025 Without vsync_start pulses, all outputs SHALL remain constant indefinitely.

Reset
REQ-026 Under rst: staging and active address = 0, start = 14, end = 15, disable = 1, blink_fast = 0, blink_off = 0, blink counter = 0, blink_state = 0, cpu_rdata = 0.
REQ-027 rst SHALL take priority over cpu_we, cpu_re and vsync_start in the same cycle.
REQ-028 rst asserted mid-frame SHALL discard pending staged writes.

Verification
REQ-029 Reset check: after rst, outputs = 0/1/14/15, blink_state 0, and reading all four registers returns 0x00, 0x00, 0x1E, 0x0F.
REQ-030 Deferred update: write CUR_LO=0x34 and CUR_HI=0x05 -> match_address stays 0x000 until vsync_start, then 0x534 one cycle later.
REQ-031 Collision: write CUR_START=0x03 in the vsync_start cycle -> start_scanline unchanged (14) and the disable flag still 1, then start_scanline = 3 and cursor_disable = 0 after the following vsync_start.
REQ-032 Blink timing: CUR_START blink_fast=0 applied, 64 vsync pulses -> blink_state toggles every 16 pulses (4 toggles); blink_fast=1 -> toggles every 8.
REQ-033 Mode switch and blink_off: counter at 12 in slow mode, switch to fast -> toggle on the applying vsync; blink_off=1 -> blink_state high, stays high over 40 pulses.
REQ-034 Read/write collision: cpu_we and cpu_re to CUR_END, old value 0x0F, new value 0x07 -> cpu_rdata = 0x0F, and a subsequent read returns 0x07.
